lbm_field_streamer: RTL and testbench

Downstream consumer of the LBM solver's macroscopic outputs. It takes one cell's `u_x`, `u_y`, `rho` each time the solver flags a valid cell and quantises the values into a packed 32-bit pixel word: an 8-bit speed code, an 8-bit density code and a 16-bit cell index. Words are buffered in a small FIFO and emitted on a valid/ready stream with row and frame markers, ready for the display/DMA path. The solver cannot be stalled, so the block absorbs backpressure and reports any drops.

---
 rtl/lbm_field_streamer.sv | 181 ++++++++++++++++++
 tb/tb_lbm_field_streamer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbm_field_streamer.sv
// Quantises per-cell LBM macroscopic values (u_x, u_y, rho) into packed pixel
// words and streams them out through a small FIFO that drops and counts on full.
module lbm_field_streamer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned GRID_W      = 50,
    parameter int unsigned GRID_H      = 50,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SPEED_SHIFT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       u_x,
    input  logic [DATA_WIDTH-1:0]       u_y,
    input  logic [DATA_WIDTH-1:0]       rho,
    input  logic                        clr_ovf,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic                        out_user,
    output logic                        overflow,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 frame_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned XW  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned YW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned SQW = 2 * DATA_WIDTH;
    localparam logic [XW-1:0]  X_MAX      = XW'(GRID_W - 1);
    localparam logic [YW-1:0]  Y_MAX      = YW'(GRID_H - 1);
    localparam logic [LW-1:0]  FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [SQW-1:0] CODE_MAX   = SQW'(255);

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } word_t;

    logic            acc, x_wrap, y_wrap;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [15:0]     idx;
    logic signed [SQW-1:0] ux_e, uy_e, ux_sq, uy_sq;
    logic [SQW-1:0]  sq_c, sq_shr;
    logic [7:0]      speed_c;
    logic            unused_rho;

    logic            s1_valid, s1_last, s1_user;
    logic [SQW-1:0]  s1_sq;
    logic [7:0]      s1_rho;
    logic [15:0]     s1_idx;
    logic            s2_valid;
    word_t           s2_word;

    word_t           mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0]   level_next;
    logic            full, do_rd, do_wr, drop;
    word_t           head_c;

    assign acc    = en & in_valid;
    assign x_wrap = (x == X_MAX);
    assign y_wrap = (y == Y_MAX);

    // Squares of two signed values are non-negative; their sum fits unsigned SQW bits.
    assign ux_e  = SQW'($signed(u_x));
    assign uy_e  = SQW'($signed(u_y));
    assign ux_sq = ux_e * ux_e;
    assign uy_sq = uy_e * uy_e;
    assign sq_c  = $unsigned(ux_sq) + $unsigned(uy_sq);
    assign unused_rho = ^rho[DATA_WIDTH-9:0];

    assign sq_shr  = s1_sq >> SPEED_SHIFT;
    assign speed_c = (sq_shr > CODE_MAX) ? 8'hFF : sq_shr[7:0];

    // Grid position advances on every accepted cell, dropped or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x           <= '0;
            y           <= '0;
            idx         <= '0;
            frame_count <= '0;
        end else if (acc) begin
            x   <= x_wrap ? '0 : x + XW'(1);
            idx <= (x_wrap && y_wrap) ? '0 : idx + 16'd1;
            if (x_wrap) begin
                y <= y_wrap ? '0 : y + YW'(1);
            end
            if (x_wrap && y_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sq    <= '0;
            s1_rho   <= '0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
            s1_user  <= 1'b0;
            s2_valid <= 1'b0;
            s2_word  <= '0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_sq   <= sq_c;
                s1_rho  <= rho[DATA_WIDTH-1 -: 8];
                s1_idx  <= idx;
                s1_last <= x_wrap;
                s1_user <= (idx == 16'd0);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= '{data: {speed_c, s1_rho, s1_idx}, last: s1_last, user: s1_user};
            end
        end
    end

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign full       = (fifo_level == FULL_LEVEL);
    assign do_rd      = out_valid & out_ready;
    assign do_wr      = s2_valid & (~full | do_rd);
    assign drop       = s2_valid & full & ~do_rd;
    assign rd_next    = do_rd ? rd_ptr + AW'(1) : rd_ptr;
    assign level_next = fifo_level + LW'(do_wr) - LW'(do_rd);
    assign head_c     = (do_wr && (wr_ptr == rd_next)) ? s2_word : mem[rd_next];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= s2_word;
        end
    end

    // Output registers shadow the head entry so the stream is fully registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_user   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_next;
            fifo_level <= level_next;
            out_valid  <= (level_next != '0);
            if (level_next != '0) begin
                out_data <= head_c.data;
                out_last <= head_c.last;
                out_user <= head_c.user;
            end
        end
    end

    // A drop in the same cycle as a clear leaves exactly that drop recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clr_ovf ? 16'd1 :
                          (drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_lbm_field_streamer.sv
// Bench for lbm_field_streamer: constant vector table, directed corner sequences
// and randomized traffic compared every cycle against a frame/FIFO reference model.
`timescale 1ns/1ps
module tb_lbm_field_streamer;
    localparam int GW    = 50;
    localparam int GH    = 50;
    localparam int DEPTH = 16;
    localparam int CELLS = GW * GH;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, clr_ovf, out_ready;
    logic [15:0] u_x, u_y, rho;
    logic        out_valid, out_last, out_user, overflow;
    logic [31:0] out_data;
    logic [15:0] drop_count, frame_count;
    logic [4:0]  fifo_level;

    always #5 clk = ~clk;

    lbm_field_streamer #(
        .DATA_WIDTH(16), .GRID_W(GW), .GRID_H(GH), .FIFO_DEPTH(DEPTH), .SPEED_SHIFT(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .u_x(u_x), .u_y(u_y), .rho(rho), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_user(out_user), .overflow(overflow),
        .drop_count(drop_count), .frame_count(frame_count), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } mword_t;

    typedef struct {
        logic [15:0] ux;
        logic [15:0] uy;
        logic [15:0] r;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_user;
    } vec_t;

    // Reference model state: words in flight (2 edges), buffered words, counters.
    mword_t mq[$];
    mword_t p0, p1;
    bit     p0_v, p1_v;
    int     cell_n, m_frames, m_drops;
    bit     m_ovf;

    int n_checks, n_err;
    bit log_en;
    int log_next, log_cnt, log_last, log_user;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic mword_t model_word(input logic [15:0] ux, input logic [15:0] uy, input logic [15:0] r);
        longint a, b, sq, code;
        mword_t w;
        a    = longint'($signed(ux));
        b    = longint'($signed(uy));
        sq   = a * a + b * b;
        code = sq / 65536;
        if (code > 255) code = 255;
        w.data = {8'(code), r[15:8], 16'(cell_n)};
        w.last = ((cell_n % GW) == GW - 1);
        w.user = (cell_n == 0);
        return w;
    endfunction

    function automatic void model_reset();
        mq.delete();
        p0_v = 0; p1_v = 0;
        cell_n = 0; m_frames = 0; m_drops = 0; m_ovf = 0;
    endfunction

    function automatic void model_edge();
        int sz0;
        bit rd, dropped;
        sz0 = mq.size();
        rd = (sz0 > 0) && out_ready;
        dropped = 0;
        if (rd) void'(mq.pop_front());
        if (p1_v) begin
            if (sz0 < DEPTH || rd) mq.push_back(p1);
            else dropped = 1;
        end
        if (dropped) begin
            m_ovf = 1;
            m_drops = clr_ovf ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
        end else if (clr_ovf) begin
            m_ovf = 0;
            m_drops = 0;
        end
        p1_v = p0_v;
        p1 = p0;
        p0_v = en && in_valid;
        if (p0_v) begin
            p0 = model_word(u_x, u_y, rho);
            if (cell_n == CELLS - 1) begin
                cell_n = 0;
                m_frames = (m_frames + 1) % 65536;
            end else begin
                cell_n++;
            end
        end
    endfunction

    function automatic void check_outputs();
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0 && out_valid) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_last", out_last, mq[0].last);
            chk("out_user", out_user, mq[0].user);
        end
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        chk("frame_count", frame_count, m_frames);
    endfunction

    task automatic step();
        if (log_en && out_valid && out_ready) begin
            chk("stream_idx", out_data[15:0], log_next);
            log_next++;
            log_cnt++;
            if (out_last) log_last++;
            if (out_user) log_user++;
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic strobe(input logic [15:0] ux, input logic [15:0] uy, input logic [15:0] r);
        u_x = ux; u_y = uy; rho = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic strobe_rand();
        strobe(16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_user", out_user, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_fifo_level", fifo_level, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    vec_t vecs[10];
    logic [31:0] held;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h0666, 16'h0000, 16'h4000, 32'h28400000, 1'b0, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 32'hFF7F0001, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0000, 16'h8000, 32'hFF800002, 1'b0, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0123, 32'h00010003, 1'b0, 1'b0};
        vecs[4] = '{16'h0800, 16'h0800, 16'hC000, 32'h80C00004, 1'b0, 1'b0};
        vecs[5] = '{16'hF800, 16'h0000, 16'h3FFF, 32'h403F0005, 1'b0, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0000, 16'h0100, 32'hFF010006, 1'b0, 1'b0};
        vecs[7] = '{16'h1000, 16'h0000, 16'h0000, 32'hFF000007, 1'b0, 1'b0};
        vecs[8] = '{16'h0100, 16'hFF00, 16'hFFFF, 32'h02FF0008, 1'b0, 1'b0};
        vecs[9] = '{16'h00FF, 16'h00FF, 16'h2000, 32'h01200009, 1'b0, 1'b0};

        n_checks = 0; n_err = 0;
        log_en = 0; log_next = 0; log_cnt = 0; log_last = 0; log_user = 0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
        u_x = '0; u_y = '0; rho = '0;
        model_reset();
        #1;
        do_reset();

        // Constant vectors, one cell at a time, including latency check.
        for (int i = 0; i < 10; i++) begin
            strobe(vecs[i].ux, vecs[i].uy, vecs[i].r);
            step();
            chk("vec_latency", out_valid, 0);
            step();
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vecs[i].exp_data);
            chk("vec_last", out_last, vecs[i].exp_last);
            chk("vec_user", out_user, vecs[i].exp_user);
        end
        idle(2);

        // Full frame with the sink always ready.
        do_reset();
        log_en = 1; log_next = 0; log_cnt = 0; log_last = 0; log_user = 0;
        for (int i = 0; i < CELLS; i++) strobe_rand();
        idle(4);
        log_en = 0;
        chk("frame_words", log_cnt, CELLS);
        chk("frame_lasts", log_last, GH);
        chk("frame_users", log_user, 1);
        chk("frame_count_1", frame_count, 1);

        // Backpressure: 20 strobes into a stalled 16-entry buffer.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) strobe_rand();
        idle(3);
        chk("bp_level", fifo_level, 16);
        chk("bp_overflow", overflow, 1);
        chk("bp_drops", drop_count, 4);
        held = out_data;
        idle(2);
        chk("bp_hold", out_data, held);
        chk("bp_head_idx", held[15:0], 0);
        out_ready = 1'b1;
        log_en = 1; log_next = 0; log_cnt = 0; log_last = 0; log_user = 0;
        idle(18);
        log_en = 0;
        chk("bp_drained", log_cnt, 16);
        strobe_rand();
        idle(2);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_idx", out_data[15:0], 20);
        idle(2);

        // Full buffer with read and write in the same cycle.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) strobe_rand();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) strobe_rand();
        idle(2);
        out_ready = 1'b0;
        chk("rw_level", fifo_level, 16);
        chk("rw_drops", drop_count, 0);
        chk("rw_overflow", overflow, 0);

        // Clear coinciding with a drop.
        strobe_rand();
        strobe_rand();
        idle(2);
        chk("clr_pre_drops", drop_count, 2);
        strobe_rand();
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_count, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_only_ovf", overflow, 0);
        chk("clr_only_cnt", drop_count, 0);

        // Reset mid-frame with words buffered.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe_rand();
        idle(3);
        chk("mid_level", fifo_level, 5);
        do_reset();
        out_ready = 1'b1;
        strobe_rand();
        idle(2);
        chk("mid_valid", out_valid, 1);
        chk("mid_idx", out_data[15:0], 0);
        chk("mid_user", out_user, 1);
        idle(2);

        // Randomized traffic with varying sink pressure.
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            int pr;
            pr = $urandom_range(0, 3);
            for (int c = 0; c < 200; c++) begin
                en        = ($urandom % 8) != 0;
                in_valid  = ($urandom % 4) != 0;
                out_ready = (pr == 0) ? (($urandom % 8) == 0) : (($urandom % (pr + 1)) != 0);
                clr_ovf   = ($urandom % 64) == 0;
                u_x = 16'($urandom); u_y = 16'($urandom); rho = 16'($urandom);
                step();
            end
        end
        en = 1'b1; in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
